// File: rtl/ayatsuki_core.sv
// Single-cycle RV32I subset core: one instruction retires per rising clk.
// Memory-side outputs are combinational from PC, inst_i and the register file.
module ayatsuki_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_i,
  output logic [31:0] inst_addr_o,
  output logic        mem_w_enable_o,
  output logic        mem_r_enable_o,
  output logic        mem_enable_o,
  output logic [31:0] mem_w_addr_o,
  output logic [31:0] mem_r_addr_o,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_y;
  logic [31:0] pc_plus4, ld_addr, st_addr, wb_data;
  logic        alu_alt, op_imm_ok, op_reg_ok, br_taken;
  logic        wb_en, rd_en, wr_en;

  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign funct3 = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign funct7 = inst_i[31:25];

  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'd0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign pc_plus4 = pc_q + 32'd4;
  assign ld_addr  = rs1_val + imm_i;
  assign st_addr  = rs1_val + imm_s;

  // funct7 only selects SUB/SRA; any other non-zero value makes the op a NOP
  assign op_imm_ok = (funct3 == 3'b001) ? (funct7 == 7'b0000000) :
                     (funct3 == 3'b101) ? (funct7 == 7'b0000000 || funct7 == 7'b0100000) : 1'b1;
  assign op_reg_ok = (funct7 == 7'b0000000) ||
                     (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
  assign alu_alt   = (opcode == OP_REG) ? funct7[5] : ((funct3 == 3'b101) && funct7[5]);
  assign alu_b     = (opcode == OP_REG) ? rs2_val : imm_i;

  // ALU shared by register-register and register-immediate forms
  always_comb begin
    alu_y = 32'd0;
    case (funct3)
      3'b000:  alu_y = alu_alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
      3'b001:  alu_y = rs1_val << alu_b[4:0];
      3'b010:  alu_y = {31'd0, ($signed(rs1_val) < $signed(alu_b))};
      3'b011:  alu_y = {31'd0, (rs1_val < alu_b)};
      3'b100:  alu_y = rs1_val ^ alu_b;
      3'b101:  alu_y = alu_alt ? 32'($signed(rs1_val) >>> alu_b[4:0]) : (rs1_val >> alu_b[4:0]);
      3'b110:  alu_y = rs1_val | alu_b;
      3'b111:  alu_y = rs1_val & alu_b;
      default: alu_y = 32'd0;
    endcase
  end

  // Branch condition; reserved funct3 values never branch
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Main decode: next PC, writeback and memory request
  always_comb begin
    pc_d    = pc_plus4;
    wb_en   = 1'b0;
    wb_data = 32'd0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    case (opcode)
      OP_LUI: begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end
      OP_AUIPC: begin
        wb_en   = 1'b1;
        wb_data = pc_q + imm_u;
      end
      OP_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        pc_d    = pc_q + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          wb_en   = 1'b1;
          wb_data = pc_plus4;
          pc_d    = (rs1_val + imm_i) & ~32'd1;
        end else begin
          wb_en   = 1'b0;
        end
      end
      OP_BRANCH: begin
        if (br_taken) begin
          pc_d = pc_q + imm_b;
        end else begin
          pc_d = pc_plus4;
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          rd_en   = 1'b1;
          wb_en   = 1'b1;
          wb_data = mem_data_i;
        end else begin
          rd_en   = 1'b0;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          wr_en = 1'b1;
        end else begin
          wr_en = 1'b0;
        end
      end
      OP_IMM: begin
        if (op_imm_ok) begin
          wb_en   = 1'b1;
          wb_data = alu_y;
        end else begin
          wb_en   = 1'b0;
        end
      end
      OP_REG: begin
        if (op_reg_ok) begin
          wb_en   = 1'b1;
          wb_data = alu_y;
        end else begin
          wb_en   = 1'b0;
        end
      end
      default: begin
        wb_en = 1'b0;
      end
    endcase
  end

  // rst_n gates the requests directly so a mid-cycle reset kills a store at once
  assign inst_addr_o    = pc_q;
  assign mem_r_enable_o = rd_en & rst_n;
  assign mem_w_enable_o = wr_en & rst_n;
  assign mem_enable_o   = mem_r_enable_o | mem_w_enable_o;
  assign mem_r_addr_o   = mem_r_enable_o ? ld_addr : 32'd0;
  assign mem_w_addr_o   = mem_w_enable_o ? st_addr : 32'd0;
  assign mem_data_o     = mem_w_enable_o ? rs2_val : 32'd0;

  // PC and register file; x0 is never written so it stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else begin
      pc_q <= pc_d;
      if (wb_en && (rd != 5'd0)) begin
        rf_q[rd] <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_ayatsuki_core.sv
// Directed, table-driven bench for ayatsuki_core: the bench plays instruction
// memory by driving inst_i for each expected PC and checks the memory-side outputs.
module tb_ayatsuki_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_o;
  logic        mem_w_enable_o;
  logic        mem_r_enable_o;
  logic        mem_enable_o;
  logic [31:0] mem_w_addr_o;
  logic [31:0] mem_r_addr_o;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;

  int checks   = 0;
  int failures = 0;

  ayatsuki_core dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst_i         (inst_i),
    .inst_addr_o    (inst_addr_o),
    .mem_w_enable_o (mem_w_enable_o),
    .mem_r_enable_o (mem_r_enable_o),
    .mem_enable_o   (mem_enable_o),
    .mem_w_addr_o   (mem_w_addr_o),
    .mem_r_addr_o   (mem_r_addr_o),
    .mem_data_i     (mem_data_i),
    .mem_data_o     (mem_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rst;
    logic [31:0] inst;
    logic [31:0] mdi;
    logic [31:0] pc;
    logic        we;
    logic        re;
    logic [31:0] waddr;
    logic [31:0] raddr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm, rd, op};
  endfunction

  task automatic add(logic rst, logic [31:0] inst, logic [31:0] mdi, logic [31:0] pc,
                     logic we, logic re, logic [31:0] waddr, logic [31:0] raddr,
                     logic [31:0] wdata);
    vec_t v;
    v.rst = rst; v.inst = inst; v.mdi = mdi; v.pc = pc; v.we = we; v.re = re;
    v.waddr = waddr; v.raddr = raddr; v.wdata = wdata;
    vt.push_back(v);
  endtask

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(int idx, logic [31:0] pc, logic we, logic re,
                         logic [31:0] waddr, logic [31:0] raddr, logic [31:0] wdata);
    chk("pc",    idx, inst_addr_o, pc);
    chk("w_en",  idx, {31'd0, mem_w_enable_o}, {31'd0, we});
    chk("r_en",  idx, {31'd0, mem_r_enable_o}, {31'd0, re});
    chk("en",    idx, {31'd0, mem_enable_o}, {31'd0, (we | re)});
    chk("waddr", idx, mem_w_addr_o, waddr);
    chk("raddr", idx, mem_r_addr_o, raddr);
    chk("wdata", idx, mem_data_o, wdata);
  endtask

  initial begin
    // Main program: ALU, store, load, edge cases, branches
    add(1'b1, enc_i(12'd5,  5'd0, 3'b000, 5'd1, 7'b0010011), 32'd0, 32'h00, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_i(12'd7,  5'd1, 3'b000, 5'd2, 7'b0010011), 32'd0, 32'h04, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_s(12'd16, 5'd2, 5'd0),                     32'd0, 32'h08, 1'b1, 1'b0, 32'd16, 32'd0, 32'd12);
    add(1'b0, enc_i(12'd16, 5'd0, 3'b010, 5'd3, 7'b0000011), 32'h0000_000C, 32'h0C, 1'b0, 1'b1, 32'd0, 32'd16, 32'd0);
    add(1'b0, enc_r(7'd0, 5'd3, 5'd3, 3'b000, 5'd4),         32'd0, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_s(12'd20, 5'd4, 5'd0),                     32'd0, 32'h14, 1'b1, 1'b0, 32'd20, 32'd0, 32'd24);
    add(1'b0, enc_i(12'd1,  5'd0, 3'b000, 5'd6, 7'b0010011), 32'd0, 32'h18, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_r(7'h20, 5'd6, 5'd0, 3'b000, 5'd5),        32'd0, 32'h1C, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_s(12'd4,  5'd5, 5'd0),                     32'd0, 32'h20, 1'b1, 1'b0, 32'd4, 32'd0, 32'hFFFF_FFFF);
    add(1'b0, enc_u(20'h80000, 5'd7, 7'b0110111),            32'd0, 32'h24, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_i(12'h41F, 5'd7, 3'b101, 5'd8, 7'b0010011), 32'd0, 32'h28, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_s(12'd8,  5'd8, 5'd0),                     32'd0, 32'h2C, 1'b1, 1'b0, 32'd8, 32'd0, 32'hFFFF_FFFF);
    add(1'b0, enc_i(12'd9,  5'd0, 3'b000, 5'd0, 7'b0010011), 32'd0, 32'h30, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_s(12'd12, 5'd0, 5'd0),                     32'd0, 32'h34, 1'b1, 1'b0, 32'd12, 32'd0, 32'd0);
    add(1'b0, 32'h0000_0000,                                 32'd0, 32'h38, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_b(13'd8, 5'd0, 5'd0, 3'b001),              32'd0, 32'h3C, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_b(13'd8, 5'd0, 5'd5, 3'b100),              32'd0, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_b(13'd8, 5'd0, 5'd5, 3'b110),              32'd0, 32'h48, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_i(12'd0,  5'd0, 3'b010, 5'd0, 7'b0000011), 32'hDEAD_BEEF, 32'h4C, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_s(12'd24, 5'd0, 5'd0),                     32'd0, 32'h50, 1'b1, 1'b0, 32'd24, 32'd0, 32'd0);
    add(1'b0, enc_u(20'h00001, 5'd9, 7'b0010111),            32'd0, 32'h54, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_r(7'd0, 5'd6, 5'd5, 3'b101, 5'd10),        32'd0, 32'h58, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_s(12'd28, 5'd9, 5'd0),                     32'd0, 32'h5C, 1'b1, 1'b0, 32'd28, 32'd0, 32'h0000_1054);
    add(1'b0, enc_s(12'd32, 5'd10, 5'd0),                    32'd0, 32'h60, 1'b1, 1'b0, 32'd32, 32'd0, 32'h7FFF_FFFF);
    add(1'b0, enc_r(7'd0, 5'd6, 5'd5, 3'b010, 5'd11),        32'd0, 32'h64, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_r(7'd0, 5'd6, 5'd5, 3'b011, 5'd12),        32'd0, 32'h68, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_s(12'd36, 5'd11, 5'd0),                    32'd0, 32'h6C, 1'b1, 1'b0, 32'd36, 32'd0, 32'd1);
    add(1'b0, enc_s(12'd40, 5'd12, 5'd0),                    32'd0, 32'h70, 1'b1, 1'b0, 32'd40, 32'd0, 32'd0);
    // Control-flow program after a fresh reset; first store shows x4 was cleared
    add(1'b1, enc_s(12'd44, 5'd4, 5'd0),                     32'd0, 32'h00, 1'b1, 1'b0, 32'd44, 32'd0, 32'd0);
    add(1'b0, NOP,                                           32'd0, 32'h04, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, NOP,                                           32'd0, 32'h08, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, NOP,                                           32'd0, 32'h0C, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_b(13'd8, 5'd0, 5'd0, 3'b000),              32'd0, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_j(21'h1F_FFF8, 5'd1),                      32'd0, 32'h18, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_i(12'd0, 5'd1, 3'b000, 5'd0, 7'b1100111),  32'd0, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_s(12'd48, 5'd1, 5'd0),                     32'd0, 32'h1C, 1'b1, 1'b0, 32'd48, 32'd0, 32'h1C);
    add(1'b0, enc_i(12'd1, 5'd1, 3'b000, 5'd2, 7'b1100111),  32'd0, 32'h20, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, enc_s(12'd52, 5'd2, 5'd0),                     32'd0, 32'h1C, 1'b1, 1'b0, 32'd52, 32'd0, 32'h24);

    // Reset held for two cycles with a store on inst_i: PC stays 0, no requests
    rst_n      = 1'b0;
    inst_i     = enc_s(12'd0, 5'd1, 5'd0);
    mem_data_i = 32'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk_all(100 + c, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    inst_i = NOP;
    #1;
    chk_all(102, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    chk_all(103, 32'd4, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    chk_all(104, 32'd8, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      if (vt[i].rst) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      inst_i     = vt[i].inst;
      mem_data_i = vt[i].mdi;
      #1;
      chk_all(i, vt[i].pc, vt[i].we, vt[i].re, vt[i].waddr, vt[i].raddr, vt[i].wdata);
    end

    // Mid-run reset during a store: request vanishes at once, PC and x1 cleared
    @(negedge clk);
    inst_i     = enc_s(12'd56, 5'd1, 5'd0);
    mem_data_i = 32'd0;
    #1;
    chk_all(200, 32'h20, 1'b1, 1'b0, 32'd56, 32'd0, 32'h1C);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all(201, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    chk_all(202, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    inst_i = enc_s(12'd60, 5'd1, 5'd0);
    #1;
    chk_all(203, 32'd0, 1'b1, 1'b0, 32'd60, 32'd0, 32'd0);
    @(negedge clk);
    inst_i = NOP;
    #1;
    chk_all(204, 32'd4, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
